// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, wrap/saturate boundary mode, tc pulse and sticky overflow.
// Optional prescaler compiled in with `define UPDOWN_MOD_COUNTER_PRESCALE_EN.
module updown_mod_counter #(
    parameter int N        = 4,
    parameter int MODULO   = 10,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         up_dn,
    input  logic         sat_mode,
    input  logic         Load,
    input  logic [N-1:0] din,
    input  logic         ovf_clr,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         ovf
);

    localparam int           MAX_I = MODULO - 1;
    localparam logic [N-1:0] MAX   = MAX_I[N-1:0];

    if (MODULO < 2 || MODULO > (1 << N)) begin : g_bad_modulo
        $error("updown_mod_counter: MODULO must be in 2..2^N");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_mod_counter: PRESCALE must be >= 1");
    end

    logic [N-1:0] r_count;
    logic         r_tc;
    logic         r_ovf;

    logic         w_step;
    logic         w_at_max;
    logic         w_at_zero;
    logic         w_boundary;
    logic [N-1:0] w_next_count;
    logic [N-1:0] w_load_val;

`ifdef UPDOWN_MOD_COUNTER_PRESCALE_EN
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;

    assign w_step = enable && (r_pre == PRE_LAST);

    // Prescaler only advances on enabled cycles; load restarts the phase.
    always_ff @(posedge clk) begin
        if (reset || Load) begin
            r_pre <= '0;
        end else if (enable) begin
            r_pre <= w_step ? '0 : r_pre + PW'(1);
        end
    end
`else
    assign w_step = enable;
`endif

    always_comb begin
        w_at_max     = (r_count == MAX);
        w_at_zero    = (r_count == '0);
        w_load_val   = (din > MAX) ? MAX : din;
        w_boundary   = 1'b0;
        w_next_count = r_count;
        if (w_step && !Load) begin
            if (up_dn) begin
                w_boundary   = w_at_max;
                w_next_count = w_at_max ? (sat_mode ? MAX : '0) : r_count + N'(1);
            end else begin
                w_boundary   = w_at_zero;
                w_next_count = w_at_zero ? (sat_mode ? '0 : MAX) : r_count - N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= Load ? w_load_val : w_next_count;
            r_tc    <= w_boundary;
            // A boundary event in the same cycle beats the clear.
            if (w_boundary) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed vector bench for updown_mod_counter at N=4, MODULO=10.
// Prescaler sequence runs only when UPDOWN_MOD_COUNTER_PRESCALE_EN is defined.
module tb_updown_mod_counter;

    localparam int N = 4;
    localparam int MODULO = 10;
    localparam int PRESCALE = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         up_dn = 1'b1;
    logic         sat_mode = 1'b0;
    logic         Load = 1'b0;
    logic [N-1:0] din = '0;
    logic         ovf_clr = 1'b0;
    logic [N-1:0] count;
    logic         tc;
    logic         ovf;

    int n_vec = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic       up;
        logic       sat;
        logic       ld;
        logic [3:0] d;
        logic       clr;
        logic [3:0] e_count;
        logic       e_tc;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    updown_mod_counter #(.N(N), .MODULO(MODULO), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
        .sat_mode(sat_mode), .Load(Load), .din(din), .ovf_clr(ovf_clr),
        .count(count), .tc(tc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic void add(string name, logic rst, logic en, logic up, logic sat,
                                logic ld, logic [3:0] d, logic clr,
                                logic [3:0] ec, logic et, logic eo);
        vec_t v;
        v.name = name; v.rst = rst; v.en = en; v.up = up; v.sat = sat;
        v.ld = ld; v.d = d; v.clr = clr; v.e_count = ec; v.e_tc = et; v.e_ovf = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [3:0] got, logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; enable = v.en; up_dn = v.up; sat_mode = v.sat;
        Load = v.ld; din = v.d; ovf_clr = v.clr;
        @(posedge clk);
        #1;
        n_vec++;
        check({v.name, ".count"}, count, v.e_count);
        check({v.name, ".tc"}, {3'b0, tc}, {3'b0, v.e_tc});
        check({v.name, ".ovf"}, {3'b0, ovf}, {3'b0, v.e_ovf});
    endtask

    task automatic drive_idle(input logic en, input logic ld, input logic [3:0] d);
        @(negedge clk);
        reset = 1'b0; enable = en; up_dn = 1'b1; sat_mode = 1'b0;
        Load = ld; din = d; ovf_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifndef UPDOWN_MOD_COUNTER_PRESCALE_EN
        //  name        rst en up sat ld din clr  count tc ovf
        add("reset",     1, 0, 1, 0, 0, 0, 0,   0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            int c;
            c = i % 10;
            add($sformatf("up_wrap%0d", i), 0, 1, 1, 0, 0, 0, 0,
                c[3:0], (i == 10), (i >= 10));
        end
        add("ld3",       0, 0, 0, 1, 1, 3, 0,   3, 0, 1);
        add("dn_sat1",   0, 1, 0, 1, 0, 0, 0,   2, 0, 1);
        add("dn_sat2",   0, 1, 0, 1, 0, 0, 0,   1, 0, 1);
        add("dn_sat3",   0, 1, 0, 1, 0, 0, 0,   0, 0, 1);
        add("dn_sat4",   0, 1, 0, 1, 0, 0, 0,   0, 1, 1);
        add("dn_sat5",   0, 1, 0, 1, 0, 0, 0,   0, 1, 1);
        add("ld14",      0, 0, 0, 0, 1, 14, 0,  9, 0, 1);
        add("dn_from9",  0, 1, 0, 0, 0, 0, 0,   8, 0, 1);
        add("ld10",      0, 0, 1, 0, 1, 10, 0,  9, 0, 1);
        add("clr_vs_set",0, 1, 1, 0, 0, 0, 1,   0, 1, 1);
        add("clr",       0, 0, 1, 0, 0, 0, 1,   0, 0, 0);
        add("hold",      0, 0, 1, 0, 0, 0, 0,   0, 0, 0);
        add("dn_wrap",   0, 1, 0, 0, 0, 0, 0,   9, 1, 1);
        add("clr2",      0, 0, 0, 0, 0, 0, 1,   9, 0, 0);
        add("up_sat1",   0, 1, 1, 1, 0, 0, 0,   9, 1, 1);
        add("up_sat2",   0, 1, 1, 1, 0, 0, 0,   9, 1, 1);
        add("sat_hold",  0, 0, 1, 1, 0, 0, 0,   9, 0, 1);
        add("ld6",       0, 0, 1, 0, 1, 6, 0,   6, 0, 1);
        add("rst_mid",   1, 1, 1, 0, 0, 0, 0,   0, 0, 0);
        add("ld5_en",    0, 1, 1, 0, 1, 5, 0,   5, 0, 0);
        add("resume",    0, 1, 1, 0, 0, 0, 0,   6, 0, 0);
        add("ld9_en",    0, 1, 1, 1, 1, 9, 0,   9, 0, 0);
        add("ld0_dn",    0, 1, 0, 0, 1, 0, 0,   0, 0, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Long down-count loop: tc must appear only on the 0 -> 9 wrap.
        begin
            int exp_c;
            exp_c = 0;
            for (int i = 0; i < 25; i++) begin
                logic e_tc;
                e_tc = (exp_c == 0);
                exp_c = (exp_c == 0) ? 9 : exp_c - 1;
                @(negedge clk);
                reset = 0; enable = 1; up_dn = 0; sat_mode = 0; Load = 0; ovf_clr = 0;
                @(posedge clk);
                #1;
                n_vec++;
                check($sformatf("dn_loop%0d.count", i), count, exp_c[3:0]);
                check($sformatf("dn_loop%0d.tc", i), {3'b0, tc}, {3'b0, e_tc});
            end
        end
`else
        // Prescaler sequence with a small reference model, up/wrap mode.
        begin
            int m_cnt, m_pre;
            logic en_pat[$];
            logic ld_pat[$];
            en_pat = '{1,1,1,1, 1,1,1,1, 1,1,0,0, 1,1,1,1, 1,1,1,1, 1,1,1,1};
            ld_pat = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,0,0, 0,0,0,0};
            @(negedge clk);
            reset = 1;
            @(posedge clk);
            #1;
            n_vec++;
            check("pre_reset.count", count, 4'd0);
            m_cnt = 0; m_pre = 0;
            foreach (en_pat[i]) begin
                logic e_tc;
                e_tc = 1'b0;
                if (ld_pat[i]) begin
                    m_cnt = 2; m_pre = 0;
                end else if (en_pat[i]) begin
                    if (m_pre == PRESCALE - 1) begin
                        m_pre = 0;
                        e_tc = (m_cnt == MODULO - 1);
                        m_cnt = (m_cnt + 1) % MODULO;
                    end else begin
                        m_pre++;
                    end
                end
                drive_idle(en_pat[i], ld_pat[i], 4'd2);
                n_vec++;
                check($sformatf("pre%0d.count", i), count, m_cnt[3:0]);
                check($sformatf("pre%0d.tc", i), {3'b0, tc}, {3'b0, e_tc});
            end
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the basic up counter.
- Adds up/down direction, a programmable modulo, a load value, and a wrap or saturate mode.
- Adds a terminal-count pulse and a sticky overflow flag.
- Used as the general event and timing counter in the datapath and control blocks; replaces fixed-width up-only counters.

Parameters:
- N, 4, count width in bits.
- MODULO, 10, count range is 0..MODULO-1. Legal range 2..2^N. MAX = MODULO-1.
- PRESCALE, 4, number of enabled cycles per count step. Used only when the prescaler feature is compiled in; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count-step request.
- up_dn  in  1  direction: 1 = up, 0 = down.
- sat_mode  in  1  boundary mode: 1 = saturate at the boundary, 0 = wrap.
- Load  in  1  synchronous load of din.
- din  in  N  load value.
- ovf_clr  in  1  clears the sticky overflow flag.
- count  out  N  current count (registered).
- tc  out  1  one-cycle terminal-count pulse (registered).
- ovf  out  1  sticky flag: a wrap or saturation event has occurred.

Behaviour:
- All state updates on the rising clk edge. All outputs are registered.
- Reset: with reset = 1 at an edge, count = 0, tc = 0, ovf = 0, prescaler = 0. Reset overrides all other inputs.
- Priority, highest first: reset, Load, enable. With no action, count holds and tc = 0.
- Load:
  - count <= din when din <= MAX; count <= MAX when din > MAX (clamp).
  - tc = 0 and the prescaler is cleared.
  - ovf is unaffected.
- Step, up_dn = 1:
  - count < MAX: count + 1.
  - count == MAX, sat_mode = 0: count <= 0; boundary event.
  - count == MAX, sat_mode = 1: count holds MAX; boundary event.
- Step, up_dn = 0:
  - count > 0: count - 1.
  - count == 0, sat_mode = 0: count <= MAX; boundary event.
  - count == 0, sat_mode = 1: count holds 0; boundary event.
- Boundary event:
  - tc = 1 in the cycle after the step edge, for exactly one cycle.
  - A repeated saturating step re-pulses tc every step.
  - ovf <= 1.
- ovf_clr: ovf <= 0, unless a boundary event occurs in the same cycle. In that case set wins and ovf = 1.
- Width rules:
  - All arithmetic is N bits and must never exceed MAX.
  - When MODULO = 2^N, the wrap matches natural N-bit overflow.
- Direction or mode changes take effect on the next step; there is no pipeline.
- Latency: one cycle from enable/Load to count and tc.
- With enable held and no boundary, count changes every cycle (every PRESCALE cycles with the prescaler feature compiled in).
- Load takes effect while enable is high, and counting resumes on the next cycle.

Optional Feature:
- Macro: UPDOWN_MOD_COUNTER_PRESCALE_EN.
- Defined:
  - An internal ceil(log2(PRESCALE))-bit prescaler counts cycles with enable = 1.
  - A count step occurs only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - With enable = 0 the prescaler holds.
  - Reset and Load clear the prescaler.
  - PRESCALE = 1 behaves identically to the undefined case.
- Undefined: every enabled cycle is a step. PRESCALE is ignored and no prescaler logic is built.

Test Plan (N=4, MODULO=10):
1. Reset, then enable=1, up_dn=1, sat_mode=0 for 12 cycles -> count 1..9, 0, 1, 2. tc high only in the cycle where count returns to 0. ovf=1 from that cycle on.
2. Load din=3, then down count with sat_mode=1 for 5 cycles -> count 2, 1, 0, 0, 0. tc pulses on the 4th and 5th cycles. ovf=1.
3. Load din=14 (greater than MAX) -> count=9 next cycle, tc=0, ovf unchanged. Then a wrapping down step gives count=8.
4. ovf=1, ovf_clr=1 in the same cycle as an up wrap at count=9 -> ovf stays 1. Next cycle ovf_clr=1 with no event -> ovf=0.
5. Mid-count (count=6, enable=1), reset=1 for one edge -> count=0, tc=0, ovf=0 next cycle. Load=1 with enable=1 and din=5 -> count=5, no increment that cycle.
6. UPDOWN_MOD_COUNTER_PRESCALE_EN defined, PRESCALE=4, enable=1 continuously -> count increments on every 4th enabled cycle. Toggling enable low for 2 cycles stretches the interval by 2. Load clears the prescaler phase.
